addsub_serial: RTL and testbench

Parametrised, digit-serial unsigned adder/subtractor with sign-magnitude result and a valid/ready handshake on both sides. Accepts two WIDTH-bit unsigned operands and an add/subtract select, computes A+B or |A−B| over multiple cycles, and returns magnitude, sign and raw carry. It is the multi-cycle, area-lean successor to the combinational 4-bit add/subtract block, for datapaths where operands stream through a handshake.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/digit_adder.sv | 18 +
 rtl/addsub_serial.sv | 138 +++++++++++++
 tb/tb_addsub_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder, shared by the ADD and FIX phases.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] t;

  assign t    = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum  = t[DIGIT-1:0];
  assign cout = t[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial unsigned add / |A-B| with sign-magnitude result and valid/ready on both sides.
// Optional saturation of add overflow with ADDSUB_SAT_EN (adds the sat port).
import addsub_pkg::*;

module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             sign,
  output logic             carry
`ifdef ADDSUB_SAT_EN
  ,
  output logic             sat
`endif
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = $clog2(N + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
  logic             c, sub_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] dx, dy, dsum;
  logic             dcout;

  // FIX reuses the slice adder as ~acc + 0 + carry, carry seeded with 1.
  always_comb begin
    dx = a_sr[DIGIT-1:0];
    dy = b_sr[DIGIT-1:0];
    if (state == FIX) begin
      dx = ~acc[DIGIT-1:0];
      dy = '0;
    end
  end

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x    (dx),
    .y    (dy),
    .cin  (c),
    .sum  (dsum),
    .cout (dcout)
  );

  // Result slices enter at the top and shift down, so after N steps acc is LSB-aligned.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last     = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      sign      <= 1'b0;
      carry     <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat       <= 1'b0;
`endif
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      c         <= 1'b0;
      sub_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr     <= a;
          b_sr     <= b ^ {WIDTH{sub}};
          c        <= sub;
          sub_q    <= sub;
          acc      <= '0;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= ADD;
        end
        ADD: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          acc  <= acc_next;
          c    <= dcout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            carry <= dcout;
            if (sub_q && !dcout) begin
              sign  <= 1'b1;
              c     <= 1'b1;
`ifdef ADDSUB_SAT_EN
              sat   <= 1'b0;
`endif
              state <= FIX;
            end else begin
              sign      <= 1'b0;
              s         <= acc_next;
`ifdef ADDSUB_SAT_EN
              sat       <= !sub_q && dcout;
              if (!sub_q && dcout) s <= '1;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        FIX: begin
          acc <= acc_next;
          c   <= dcout;
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt       <= '0;
            s         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed scoreboard bench for addsub_serial (WIDTH=8, DIGIT=2).
module tb_addsub_serial;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] s;
  logic       sign, carry;
`ifdef ADDSUB_SAT_EN
  logic       sat;
`endif

  typedef struct {
    logic [7:0] s;
    logic       sign;
    logic       carry;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .sign      (sign),
    .carry     (carry)
`ifdef ADDSUB_SAT_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per accepted output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got s=%0h with no pending request", s);
        end else begin
          e = sb.pop_front();
          chk("s", 32'(s), 32'(e.s));
          chk("sign", 32'(sign), 32'(e.sign));
          chk("carry", 32'(carry), 32'(e.carry));
`ifdef ADDSUB_SAT_EN
          chk("sat", 32'(sat), 32'(e.sat));
`endif
        end
      end
    end
  end

  task automatic run(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                     input logic [7:0] es, input logic esign, input logic ecarry,
                     input logic esat, input int lat, input int hold);
    exp_t e;
    int   n;
    logic [7:0] ss;
    logic       ssign, scarry;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    out_ready = (hold == 0);
    e.s = es; e.sign = esign; e.carry = ecarry; e.sat = esat;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk("latency", 32'(n), 32'(lat));
    if (hold > 0) begin
      ss = s; ssign = sign; scarry = carry;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_s_stable", 32'(s), 32'(ss));
        chk("bp_sign_stable", 32'(sign), 32'(ssign));
        chk("bp_carry_stable", 32'(carry), 32'(scarry));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    end else begin
      @(posedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
`ifdef ADDSUB_SAT_EN
    chk("rst_sat", 32'(sat), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    //   a      b      sub   s      sign  carry sat   lat hold
    run(8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 5, 0);
    run(8'h13, 8'h25, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 9, 0);
    run(8'h40, 8'h40, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5, 0);
    run(8'hF0, 8'h20, 1'b0, SAT ? 8'hFF : 8'h10, 1'b0, 1'b1, SAT, 5, 0);
    run(8'hFF, 8'h01, 1'b0, SAT ? 8'hFF : 8'h00, 1'b0, 1'b1, SAT, 5, 0);
    run(8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 9, 0);
    run(8'h80, 8'h7F, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 5, 0);
    run(8'h7A, 8'h05, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 5, 2);

    // Abort in the middle of FIX: no result may appear.
    @(negedge clk);
    a = 8'h01; b = 8'hFF; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    chk("abort_idle_in_ready", 32'(in_ready), 32'd1);

    run(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 5, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
